decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 SHALL have parameters, one per line:
- PcWidth, 16, instruction address width
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp (active-mask width)
- RegIdxWidth, 8, register index width
REQ-002 SHALL derive WidWidth = max(1, $clog2(NumWarps)).
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  clock; one clock, all state on rising edge
- rst_i  in  1  reset; synchronous, active-high
- fe_valid_i  in  1  fetched instruction valid
- fe_ready_o  out  1  decoder accepts fetched instruction
- fe_pc_i  in  PcWidth  instruction address
- fe_wid_i  in  WidWidth  issuing warp
- fe_mask_i  in  WarpWidth  active thread mask
- fe_inst_i  in  32  raw instruction word
- disp_valid_o  out  1  decoded instruction valid
- disp_ready_i  in  1  dispatcher accepts
- disp_pc_o  out  PcWidth  pc
- disp_wid_o  out  WidWidth  warp
- disp_mask_o  out  WarpWidth  mask
- disp_inst_o  out  inst_t  eu + subtype
- disp_dst_o  out  RegIdxWidth  destination register
- disp_op0_o  out  RegIdxWidth  operand 0
- disp_op1_o  out  RegIdxWidth  operand 1
- jmp_valid_o  out  1  pc redirect pulse, no backpressure
- jmp_wid_o  out  WidWidth  redirected warp
- jmp_pc_o  out  PcWidth  redirect target
- sync_release_o  out  NumWarps  one-cycle barrier-release mask
- sync_waiting_o  out  NumWarps  warps parked at barrier
- error_o  out  1  sticky illegal-instruction flag

Function
REQ-004 SHALL split fe_inst_i as [31:30] eu, [29:24] subtype, [23:16] dst, [15:8] op0, [7:0] op1.
REQ-005 SHALL handshake: a transfer occurs when valid && ready, on both channels.
REQ-006 SHALL hold one output register; fe_ready_o = !disp_valid_o || disp_ready_i, combinational, with no other input dependence.
REQ-007 SHALL load non-JMP/SYNC instructions into the output register with 1-cycle latency; the register holds stable while disp_valid_o && !disp_ready_i.
REQ-008 SHALL, on a BRU_JMP transfer, not load the output register and assert jmp_valid_o for exactly one cycle in the next cycle.
REQ-009 SHALL compute the JMP target as jmp_pc_o = fe_pc_i + sign-extended {op0,op1}, truncated to PcWidth, wrapping modulo 2^PcWidth.
REQ-010 SHALL, on a BRU_SYNC transfer, not load the output register and set sync_waiting_o[fe_wid_i] in the next cycle.
REQ-011 SHALL ignore a SYNC from an already-waiting warp, leaving all state unchanged.
REQ-012 SHALL, when sync_waiting_o is all ones, pulse sync_release_o = all ones for one cycle and clear sync_waiting_o in that same cycle.
REQ-013 SHALL accept a SYNC in the release cycle as a new barrier entry, so that only that warp's bit is set afterwards.
REQ-014 SHALL forward BRU_BEZ/BRU_BNZ and all IU/LSU instructions to dispatch unmodified.

Reset
REQ-015 SHALL, with rst_i high at a clock edge, clear disp_valid_o, jmp_valid_o, sync_waiting_o, sync_release_o and error_o, and zero all disp_*/jmp_* data outputs.
REQ-016 SHALL discard any instruction pending in the output register or barrier when reset occurs mid-operation.

Configuration
REQ-017 SHALL gate illegal-instruction checking with macro BGPU_DEC_ILLEGAL_CHECK_EN.
REQ-018 SHALL, when the macro is defined, treat as illegal eu == 3 or a subtype not defined for its eu.
REQ-019 SHALL, when the macro is defined, consume an illegal instruction (fe_ready_o honoured), drop it without dispatch, and set error_o sticky until reset.
REQ-020 SHALL, when the macro is undefined, forward all non-JMP/SYNC words unchanged and tie error_o to 0.

Structure
REQ-021 SHALL place the instruction field offsets/widths and a packed decoded-instruction struct (inst_t, dst, op0, op1) in bgpu_pkg.
REQ-022 SHALL implement barrier bookkeeping (REQ-010 to REQ-013) in sub-module barrier_tracker, with ports clk_i, rst_i, sync_valid_i, sync_wid_i, waiting_o, release_o.

Verification
REQ-023 SHALL cover: IU_ADD word 0x05_03_01_02 (eu=0, subtype=0x05), wid 2 -> next cycle disp_valid_o=1, dst=3, op0=1, op1=2.
REQ-024 SHALL cover: disp_ready_i=0 for 3 cycles with a second instruction offered -> fe_ready_o=0 and outputs stable; first beat delivered on ready, second beat on the following cycle.
REQ-025 SHALL cover: JMP at pc 0x0010 with offset 0xFFF0 -> one-cycle jmp_valid_o, jmp_pc_o=0x0000, no dispatch; JMP at 0xFFFF with offset 2 -> jmp_pc_o=0x0001.
REQ-026 SHALL cover: SYNC from warps 0..7 in order -> waiting=0x7F after warp 6; the cycle after warp 7 sync_release_o=0xFF and waiting=0x00; a duplicate SYNC from warp 3 changes nothing.
REQ-027 SHALL cover: rst_i asserted while disp_valid_o=1 and waiting=0x0F -> next cycle all outputs 0.
REQ-028 SHALL cover: with BGPU_DEC_ILLEGAL_CHECK_EN, word eu=3 -> consumed, no dispatch, error_o=1 until reset; without the macro -> dispatched and error_o=0.

Source files
------------

// File: rtl/bgpu_pkg.sv
// Shared decode definitions: instruction field layout, execution-unit and subtype
// encodings, and the decoded-instruction payload.
package bgpu_pkg;

  localparam int unsigned InstWidth     = 32;
  localparam int unsigned EuLsb         = 30;
  localparam int unsigned EuWidth       = 2;
  localparam int unsigned SubLsb        = 24;
  localparam int unsigned SubWidth      = 6;
  localparam int unsigned DstLsb        = 16;
  localparam int unsigned Op0Lsb        = 8;
  localparam int unsigned Op1Lsb        = 0;
  localparam int unsigned RegFieldWidth = 8;

  typedef enum logic [EuWidth-1:0] {
    EU_IU   = 2'd0,
    EU_LSU  = 2'd1,
    EU_BRU  = 2'd2,
    EU_RSVD = 2'd3
  } eu_e;

  // Subtype encodings; each unit defines subtypes 0 .. <Unit>NumSub-1
  localparam logic [SubWidth-1:0] IU_ADD    = 6'h05;
  localparam logic [SubWidth-1:0] IuNumSub  = 6'd16;
  localparam logic [SubWidth-1:0] LSU_LD    = 6'h00;
  localparam logic [SubWidth-1:0] LSU_ST    = 6'h01;
  localparam logic [SubWidth-1:0] LsuNumSub = 6'd4;
  localparam logic [SubWidth-1:0] BRU_BEZ   = 6'h00;
  localparam logic [SubWidth-1:0] BRU_BNZ   = 6'h01;
  localparam logic [SubWidth-1:0] BRU_JMP   = 6'h02;
  localparam logic [SubWidth-1:0] BRU_SYNC  = 6'h03;
  localparam logic [SubWidth-1:0] BruNumSub = 6'd4;

  typedef struct packed {
    eu_e                 eu;
    logic [SubWidth-1:0] subtype;
  } inst_t;

  typedef struct packed {
    inst_t                    inst;
    logic [RegFieldWidth-1:0] dst;
    logic [RegFieldWidth-1:0] op0;
    logic [RegFieldWidth-1:0] op1;
  } dec_inst_t;

  function automatic dec_inst_t split_inst(input logic [InstWidth-1:0] w);
    dec_inst_t d;
    d.inst.eu      = eu_e'(w[EuLsb +: EuWidth]);
    d.inst.subtype = w[SubLsb +: SubWidth];
    d.dst          = w[DstLsb +: RegFieldWidth];
    d.op0          = w[Op0Lsb +: RegFieldWidth];
    d.op1          = w[Op1Lsb +: RegFieldWidth];
    return d;
  endfunction

  function automatic logic inst_legal(input inst_t i);
    case (i.eu)
      EU_IU:   return i.subtype < IuNumSub;
      EU_LSU:  return i.subtype < LsuNumSub;
      EU_BRU:  return i.subtype < BruNumSub;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/barrier_tracker.sv
// Warp barrier bookkeeping: collects SYNC arrivals and releases every warp once
// all of them are parked.
module barrier_tracker #(
  parameter int unsigned NumWarps = 8,
  parameter int unsigned WidWidth = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sync_valid_i,
  input  logic [WidWidth-1:0] sync_wid_i,
  output logic [NumWarps-1:0] waiting_o,
  output logic [NumWarps-1:0] release_o
);

  logic [NumWarps-1:0] waiting_q, waiting_d;
  logic [NumWarps-1:0] release_q, release_d;
  logic [NumWarps-1:0] entry;

  // The last arrival triggers release directly, so waiting never reads all ones.
  always_comb begin
    entry     = '0;
    release_d = '0;
    if (sync_valid_i) entry[sync_wid_i] = 1'b1;
    waiting_d = waiting_q | entry;
    if (&waiting_d) begin
      release_d = '1;
      waiting_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waiting_q <= '0;
      release_q <= '0;
    end else begin
      waiting_q <= waiting_d;
      release_q <= release_d;
    end
  end

  assign waiting_o = waiting_q;
  assign release_o = release_q;

endmodule

// File: rtl/decoder.sv
// Instruction decoder: one-deep dispatch register, jump redirect and barrier
// handling. Optional illegal-instruction checking via BGPU_DEC_ILLEGAL_CHECK_EN.
module decoder
  import bgpu_pkg::*;
#(
  parameter int unsigned PcWidth     = 16,
  parameter int unsigned NumWarps    = 8,
  parameter int unsigned WarpWidth   = 32,
  parameter int unsigned RegIdxWidth = 8,
  localparam int unsigned WidWidth   = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fe_valid_i,
  output logic                   fe_ready_o,
  input  logic [PcWidth-1:0]     fe_pc_i,
  input  logic [WidWidth-1:0]    fe_wid_i,
  input  logic [WarpWidth-1:0]   fe_mask_i,
  input  logic [31:0]            fe_inst_i,
  output logic                   disp_valid_o,
  input  logic                   disp_ready_i,
  output logic [PcWidth-1:0]     disp_pc_o,
  output logic [WidWidth-1:0]    disp_wid_o,
  output logic [WarpWidth-1:0]   disp_mask_o,
  output inst_t                  disp_inst_o,
  output logic [RegIdxWidth-1:0] disp_dst_o,
  output logic [RegIdxWidth-1:0] disp_op0_o,
  output logic [RegIdxWidth-1:0] disp_op1_o,
  output logic                   jmp_valid_o,
  output logic [WidWidth-1:0]    jmp_wid_o,
  output logic [PcWidth-1:0]     jmp_pc_o,
  output logic [NumWarps-1:0]    sync_release_o,
  output logic [NumWarps-1:0]    sync_waiting_o,
  output logic                   error_o
);

  dec_inst_t dec;
  logic      is_jmp, is_sync, illegal, fe_fire, load;
  logic signed [15:0] jmp_off;

  logic                   disp_valid_q, disp_valid_d;
  logic [PcWidth-1:0]     disp_pc_q, disp_pc_d;
  logic [WidWidth-1:0]    disp_wid_q, disp_wid_d;
  logic [WarpWidth-1:0]   disp_mask_q, disp_mask_d;
  inst_t                  disp_inst_q, disp_inst_d;
  logic [RegIdxWidth-1:0] disp_dst_q, disp_dst_d;
  logic [RegIdxWidth-1:0] disp_op0_q, disp_op0_d;
  logic [RegIdxWidth-1:0] disp_op1_q, disp_op1_d;
  logic                   jmp_valid_q, jmp_valid_d;
  logic [WidWidth-1:0]    jmp_wid_q, jmp_wid_d;
  logic [PcWidth-1:0]     jmp_pc_q, jmp_pc_d;

  assign dec        = split_inst(fe_inst_i);
  assign is_jmp     = (dec.inst.eu == EU_BRU) && (dec.inst.subtype == BRU_JMP);
  assign is_sync    = (dec.inst.eu == EU_BRU) && (dec.inst.subtype == BRU_SYNC);
  assign fe_ready_o = !disp_valid_q || disp_ready_i;
  assign fe_fire    = fe_valid_i && fe_ready_o;
  assign load       = fe_fire && !is_jmp && !is_sync && !illegal;
  assign jmp_off    = {dec.op0, dec.op1};

`ifdef BGPU_DEC_ILLEGAL_CHECK_EN
  logic error_q, error_d;

  assign illegal = !inst_legal(dec.inst);
  assign error_d = error_q || (fe_fire && illegal);

  always_ff @(posedge clk_i) begin
    if (rst_i) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign error_o = error_q;
`else
  assign illegal = 1'b0;
  assign error_o = 1'b0;
`endif

  // Output register next-state; a draining beat is replaced or cleared.
  always_comb begin
    disp_valid_d = disp_valid_q;
    disp_pc_d    = disp_pc_q;
    disp_wid_d   = disp_wid_q;
    disp_mask_d  = disp_mask_q;
    disp_inst_d  = disp_inst_q;
    disp_dst_d   = disp_dst_q;
    disp_op0_d   = disp_op0_q;
    disp_op1_d   = disp_op1_q;
    jmp_valid_d  = fe_fire && is_jmp;
    jmp_wid_d    = jmp_wid_q;
    jmp_pc_d     = jmp_pc_q;
    if (disp_valid_q && disp_ready_i) disp_valid_d = 1'b0;
    if (load) begin
      disp_valid_d = 1'b1;
      disp_pc_d    = fe_pc_i;
      disp_wid_d   = fe_wid_i;
      disp_mask_d  = fe_mask_i;
      disp_inst_d  = dec.inst;
      disp_dst_d   = RegIdxWidth'(dec.dst);
      disp_op0_d   = RegIdxWidth'(dec.op0);
      disp_op1_d   = RegIdxWidth'(dec.op1);
    end
    if (fe_fire && is_jmp) begin
      jmp_wid_d = fe_wid_i;
      jmp_pc_d  = fe_pc_i + PcWidth'(jmp_off);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_valid_q <= 1'b0;
      disp_pc_q    <= '0;
      disp_wid_q   <= '0;
      disp_mask_q  <= '0;
      disp_inst_q  <= '0;
      disp_dst_q   <= '0;
      disp_op0_q   <= '0;
      disp_op1_q   <= '0;
      jmp_valid_q  <= 1'b0;
      jmp_wid_q    <= '0;
      jmp_pc_q     <= '0;
    end else begin
      disp_valid_q <= disp_valid_d;
      disp_pc_q    <= disp_pc_d;
      disp_wid_q   <= disp_wid_d;
      disp_mask_q  <= disp_mask_d;
      disp_inst_q  <= disp_inst_d;
      disp_dst_q   <= disp_dst_d;
      disp_op0_q   <= disp_op0_d;
      disp_op1_q   <= disp_op1_d;
      jmp_valid_q  <= jmp_valid_d;
      jmp_wid_q    <= jmp_wid_d;
      jmp_pc_q     <= jmp_pc_d;
    end
  end

  barrier_tracker #(
    .NumWarps (NumWarps),
    .WidWidth (WidWidth)
  ) u_barrier (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sync_valid_i (fe_fire && is_sync),
    .sync_wid_i   (fe_wid_i),
    .waiting_o    (sync_waiting_o),
    .release_o    (sync_release_o)
  );

  assign disp_valid_o = disp_valid_q;
  assign disp_pc_o    = disp_pc_q;
  assign disp_wid_o   = disp_wid_q;
  assign disp_mask_o  = disp_mask_q;
  assign disp_inst_o  = disp_inst_q;
  assign disp_dst_o   = disp_dst_q;
  assign disp_op0_o   = disp_op0_q;
  assign disp_op1_o   = disp_op1_q;
  assign jmp_valid_o  = jmp_valid_q;
  assign jmp_wid_o    = jmp_wid_q;
  assign jmp_pc_o     = jmp_pc_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: dispatch beats go through a scoreboard queue,
// jump/barrier/reset/illegal behaviour is checked directly.
module tb_decoder;
  import bgpu_pkg::*;

  localparam int unsigned PcW   = 16;
  localparam int unsigned NW    = 8;
  localparam int unsigned WW    = 32;
  localparam int unsigned RW    = 8;
  localparam int unsigned WidW  = 3;
  localparam int unsigned BeatW = PcW + WidW + WW + 32;

  logic            clk, rst;
  logic            fe_valid, fe_ready;
  logic [PcW-1:0]  fe_pc;
  logic [WidW-1:0] fe_wid;
  logic [WW-1:0]   fe_mask;
  logic [31:0]     fe_inst;
  logic            disp_valid, disp_ready;
  logic [PcW-1:0]  disp_pc;
  logic [WidW-1:0] disp_wid;
  logic [WW-1:0]   disp_mask;
  inst_t           disp_inst;
  logic [RW-1:0]   disp_dst, disp_op0, disp_op1;
  logic            jmp_valid;
  logic [WidW-1:0] jmp_wid;
  logic [PcW-1:0]  jmp_pc;
  logic [NW-1:0]   sync_release, sync_waiting;
  logic            error;

  int checks = 0;
  int errors = 0;
  logic [BeatW-1:0] exp_q[$];
  logic [BeatW-1:0] disp_beat;
  logic [NW-1:0]    exp_wait;
  logic [WW-1:0]    mask_a;

  decoder #(
    .PcWidth(PcW), .NumWarps(NW), .WarpWidth(WW), .RegIdxWidth(RW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .fe_valid_i(fe_valid), .fe_ready_o(fe_ready), .fe_pc_i(fe_pc),
    .fe_wid_i(fe_wid), .fe_mask_i(fe_mask), .fe_inst_i(fe_inst),
    .disp_valid_o(disp_valid), .disp_ready_i(disp_ready), .disp_pc_o(disp_pc),
    .disp_wid_o(disp_wid), .disp_mask_o(disp_mask), .disp_inst_o(disp_inst),
    .disp_dst_o(disp_dst), .disp_op0_o(disp_op0), .disp_op1_o(disp_op1),
    .jmp_valid_o(jmp_valid), .jmp_wid_o(jmp_wid), .jmp_pc_o(jmp_pc),
    .sync_release_o(sync_release), .sync_waiting_o(sync_waiting), .error_o(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign disp_beat = {disp_pc, disp_wid, disp_mask, disp_inst, disp_dst, disp_op0, disp_op1};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BeatW-1:0] mk_beat(input logic [PcW-1:0] pc, input logic [WidW-1:0] wid,
                                               input logic [WW-1:0] mask, input logic [31:0] word);
    return {pc, wid, mask, word};
  endfunction

  // Scoreboard: every accepted dispatch beat must match the oldest expectation.
  always @(negedge clk) begin
    logic [BeatW-1:0] e;
    if (!rst && disp_valid && disp_ready) begin
      if (exp_q.size() == 0) check_eq("disp_unexpected", 128'(exp_q.size()), 128'(1));
      else begin
        e = exp_q.pop_front();
        check_eq("disp_beat", 128'(disp_beat), 128'(e));
      end
    end
  end

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [PcW-1:0] pc, input logic [WidW-1:0] wid,
                      input logic [WW-1:0] mask, input logic [31:0] word);
    int n;
    fe_valid = 1'b1;
    fe_pc    = pc;
    fe_wid   = wid;
    fe_mask  = mask;
    fe_inst  = word;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fe_ready && n < 50);
    if (!fe_ready) check_eq("send_timeout", 128'(fe_ready), 128'(1));
    @(posedge clk);
    #1;
    fe_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_fwd(input logic [PcW-1:0] pc, input logic [WidW-1:0] wid,
                          input logic [WW-1:0] mask, input logic [31:0] word);
    exp_q.push_back(mk_beat(pc, wid, mask, word));
    send(pc, wid, mask, word);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0]  eu;
    logic [5:0]  sub;
    logic [31:0] w;
    rst = 1'b1; fe_valid = 1'b0; fe_pc = '0; fe_wid = '0; fe_mask = '0; fe_inst = '0;
    disp_ready = 1'b1; exp_wait = '0; mask_a = 32'hA5A5_0F0F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_disp_valid", 128'(disp_valid), 128'(0));
    check_eq("rst_disp_beat", 128'(disp_beat), 128'(0));
    check_eq("rst_jmp", 128'({jmp_valid, jmp_wid, jmp_pc}), 128'(0));
    check_eq("rst_sync", 128'({sync_waiting, sync_release}), 128'(0));
    check_eq("rst_error", 128'(error), 128'(0));
    check_eq("rst_fe_ready", 128'(fe_ready), 128'(1));
    @(posedge clk); #1; rst = 1'b0;

    // IU_ADD, one-cycle latency
    send_fwd(16'h0100, 3'd2, mask_a, 32'h0503_0102);
    @(negedge clk);
    check_eq("add_valid", 128'(disp_valid), 128'(1));
    check_eq("add_regs", 128'({disp_dst, disp_op0, disp_op1}), 128'(24'h03_01_02));
    check_eq("add_wid", 128'(disp_wid), 128'(2));
    @(posedge clk); #1;

    // Back-to-back forwarding of IU, LSU, BEZ/BNZ
    for (int i = 0; i < 9; i++) begin
      eu  = 2'(i % 3);
      sub = (eu == 2'd0) ? 6'($urandom_range(0, 15)) :
            (eu == 2'd1) ? 6'($urandom_range(0, 3))  : 6'($urandom_range(0, 1));
      w   = {eu, sub, 24'($urandom)};
      send_fwd(16'($urandom), 3'($urandom), $urandom, w);
    end
    @(negedge clk);
    @(posedge clk); #1;

    // Backpressure: hold A for 3 cycles with B offered
    disp_ready = 1'b0;
    send_fwd(16'h1111, 3'd1, mask_a, 32'h0101_0203);
    exp_q.push_back(mk_beat(16'h2222, 3'd5, ~mask_a, 32'h4110_2030));
    fe_valid = 1'b1; fe_pc = 16'h2222; fe_wid = 3'd5; fe_mask = ~mask_a; fe_inst = 32'h4110_2030;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_fe_ready", 128'(fe_ready), 128'(0));
      check_eq("stall_hold", 128'(disp_beat), 128'(mk_beat(16'h1111, 3'd1, mask_a, 32'h0101_0203)));
    end
    @(posedge clk); #1; disp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; fe_valid = 1'b0;
    @(negedge clk);
    check_eq("stall_second", 128'({disp_valid, disp_pc}), 128'({1'b1, 16'h2222}));
    @(posedge clk); #1;

    // JMP with negative offset and with wraparound
    send(16'h0010, 3'd4, mask_a, 32'h8200_FFF0);
    @(negedge clk);
    check_eq("jmp1_pulse", 128'({jmp_valid, jmp_wid, jmp_pc}), 128'({1'b1, 3'd4, 16'h0000}));
    check_eq("jmp1_no_disp", 128'(disp_valid), 128'(0));
    @(negedge clk);
    check_eq("jmp1_one_cycle", 128'(jmp_valid), 128'(0));
    @(posedge clk); #1;
    send(16'hFFFF, 3'd1, mask_a, 32'h8200_0002);
    @(negedge clk);
    check_eq("jmp2_wrap", 128'({jmp_valid, jmp_pc}), 128'({1'b1, 16'h0001}));
    @(posedge clk); #1;

    // Barrier: warps 0..6, with a duplicate from warp 3
    for (int wd = 0; wd < 7; wd++) begin
      send(16'h0200, 3'(wd), mask_a, 32'h8300_0000);
      exp_wait[wd] = 1'b1;
      @(negedge clk);
      check_eq("sync_wait", 128'({sync_waiting, sync_release}), 128'({exp_wait, 8'h00}));
      @(posedge clk); #1;
      if (wd == 3) begin
        send(16'h0204, 3'd3, mask_a, 32'h8300_0000);
        @(negedge clk);
        check_eq("sync_dup", 128'({sync_waiting, sync_release}), 128'({8'h0F, 8'h00}));
        @(posedge clk); #1;
      end
    end
    check_eq("sync_after6", 128'(sync_waiting), 128'(8'h7F));
    // Warp 7 releases; warp 5 arrives in the release cycle
    send(16'h0208, 3'd7, mask_a, 32'h8300_0000);
    fe_valid = 1'b1; fe_wid = 3'd5; fe_inst = 32'h8300_0000;
    @(negedge clk);
    check_eq("sync_release", 128'({sync_waiting, sync_release}), 128'({8'h00, 8'hFF}));
    @(posedge clk); #1; fe_valid = 1'b0;
    @(negedge clk);
    check_eq("sync_reentry", 128'({sync_waiting, sync_release}), 128'({8'h20, 8'h00}));
    @(posedge clk); #1;

    // Reset mid-operation
    do_reset();
    for (int wd = 0; wd < 4; wd++) send(16'h0300, 3'(wd), mask_a, 32'h8300_0000);
    disp_ready = 1'b0;
    send_fwd(16'h0400, 3'd6, mask_a, 32'h0503_0102);
    @(negedge clk);
    check_eq("prerst_state", 128'({disp_valid, sync_waiting}), 128'({1'b1, 8'h0F}));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_disp", 128'({disp_valid, disp_beat}), 128'(0));
    check_eq("midrst_other", 128'({jmp_valid, jmp_wid, jmp_pc, sync_waiting, sync_release, error}), 128'(0));
    @(posedge clk); #1; rst = 1'b0; exp_q.delete(); disp_ready = 1'b1;

    // Reserved eu
`ifdef BGPU_DEC_ILLEGAL_CHECK_EN
    send(16'h0500, 3'd2, mask_a, 32'hC012_3456);
    @(negedge clk);
    check_eq("ill_no_disp", 128'(disp_valid), 128'(0));
    check_eq("ill_error", 128'(error), 128'(1));
    @(posedge clk); #1;
    send_fwd(16'h0504, 3'd2, mask_a, 32'h0503_0102);
    repeat (3) @(negedge clk);
    check_eq("ill_sticky", 128'(error), 128'(1));
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check_eq("ill_cleared", 128'(error), 128'(0));
`else
    send_fwd(16'h0500, 3'd2, mask_a, 32'hC012_3456);
    @(negedge clk);
    check_eq("rsvd_disp", 128'({disp_valid, disp_inst}), 128'({1'b1, 8'hC0}));
    check_eq("rsvd_error", 128'(error), 128'(0));
`endif
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
